clk_gate_ctrl: RTL and testbench
================================

# clk_gate_ctrl

Multi-channel automatic clock-gating controller: the parametrised successor to the single-channel latch-and-AND gate. Each of `NUM_CH` channels has its own glitch-free gate, where the enable is latched while `CLK` is low and ANDed with `CLK`. The gate enable comes from a per-channel idle-detect/wake state machine with programmable hysteresis and a request/acknowledge wake handshake. The block sits at the clock root of a subsystem and feeds one gated clock per functional unit.

## Interface
- `NUM_CH`, 4: number of independent gated-clock channels.
- `IDLE_W`, 8: width of the idle counter and of `IDLE_THRESH`.
- `WAKE_CYC`, 2: cycles (≥1) of running clock a waking channel gets before acknowledge.

- `CLK`  in  1  free-running source clock; all state updates on rising edge.
- `RST`  in  1  reset. One clock; reset is synchronous and active-high.
- `BUSY`  in  NUM_CH  per-channel activity; 1 = unit has work this cycle.
- `WAKE_REQ`  in  NUM_CH  per-channel wake request. Level; held by the requester until `WAKE_ACK`.
- `WAKE_ACK`  out  NUM_CH  per-channel wake acknowledge; channel clock guaranteed running.
- `FORCE_ON`  in  1  global bypass: all gates open while high (scan/debug).
- `IDLE_THRESH`  in  IDLE_W  idle cycles before gating; 0 = auto-gating disabled.
- `CH_ON`  out  NUM_CH  registered per-channel enable (FSM view, excludes `FORCE_ON`).
- `GATED_CLK`  out  NUM_CH  gated clocks.

## Operation
- Per-channel FSM with 2-bit state, states ON, DRAIN, OFF, WAKE. Per-channel counter is `IDLE_W` bits wide, shared between idle count and wake count.
- Activity is `act = BUSY[i] | WAKE_REQ[i]`.
- ON:
  - `act` = 0 and `IDLE_THRESH` ≠ 0 → DRAIN, counter = 1.
  - Otherwise stay in ON.
- DRAIN:
  - `act` = 1 → ON, counter = 0. Activity has priority over expiry.
  - Else if counter ≥ `IDLE_THRESH` → OFF. Compare against the live threshold, so lowering it mid-drain takes effect next cycle.
  - Else counter +1, saturating at all-ones.
  - `IDLE_THRESH` becoming 0 in DRAIN → ON.
- OFF:
  - `act` = 1 → WAKE, counter = 1. `BUSY` in OFF also wakes the channel.
- WAKE:
  - counter = `WAKE_CYC` → ON, counter = 0.
  - Else counter +1.
  - `WAKE_REQ` dropping in WAKE does not abort; the channel still reaches ON.
- `CH_ON[i]` = 1 in ON, DRAIN and WAKE; 0 in OFF. It is the registered state decode.
- `WAKE_ACK[i] = WAKE_REQ[i] & (state == ON)`, combinational from the state register. It is forced 0 while `RST` = 1.
- Gate enable: `en[i] = CH_ON[i] | FORCE_ON | RST`. Clocks run during reset so downstream synchronous resets complete.
- Gate: a level latch per channel, transparent while `CLK` = 0, capturing `en[i]`. `GATED_CLK[i] = CLK & latch[i]`. No glitch when `en` changes during `CLK` high.
- Channels are fully independent; there is no cross-channel arbitration.

## Timing
- Reset:
  - State ON, counters 0, `CH_ON` all 1, `WAKE_ACK` 0.
  - `GATED_CLK` toggles with `CLK` throughout reset.
- Reset asserted mid-DRAIN or mid-WAKE: state ON at the next edge. A pending `WAKE_REQ` is acknowledged in the first cycle after `RST` deasserts.
- Gate-off latency: after the last active cycle, `CH_ON` falls at edge `IDLE_THRESH`+1. The first suppressed `GATED_CLK` high phase is the one following that edge.
  - Example, `IDLE_THRESH` = 3, last activity in cycle 0:
    - DRAIN at edge 1 (counter 1), counter 2 at edge 2, counter 3 at edge 3.
    - OFF at edge 4, so `CH_ON` falls at edge 4.
  - Generally, `CH_ON` falls at edge `IDLE_THRESH`+1 after the last active cycle.
- Wake latency:
  - `WAKE_REQ` seen at edge k in OFF → WAKE at k. The first gated rising edge is at k+1, since the latch opens in the low phase after k.
  - ON at edge k+`WAKE_CYC`; `WAKE_ACK` high in the cycle after edge k+`WAKE_CYC`.
  - With `WAKE_CYC` = 2 the gated domain sees ≥2 rising edges before `WAKE_ACK`.
- `WAKE_REQ` while ON or DRAIN: `WAKE_ACK` in the same cycle (ON) or the next cycle (DRAIN → ON).
- `FORCE_ON` does not alter FSM state or `CH_ON`. The counters continue, so a channel may reach OFF while forced. Its gate closes on the first `CLK`-low phase after `FORCE_ON` falls.

## Test plan
- Reset/bypass:
  - Stimulus: hold `RST` 5 cycles with `BUSY` = 0 and `IDLE_THRESH` = 3.
  - Required: all `GATED_CLK` toggle 5 times, `CH_ON` = 4'b1111, `WAKE_ACK` = 0.
  - After release: `CH_ON` = 4'b0000 at edge 4 after release.
- Idle hysteresis:
  - Stimulus: `IDLE_THRESH` = 3; `BUSY[0]` pulses at cycles 0 and 3.
  - Required: `CH_ON[0]` stays 1. After the cycle-3 pulse, `CH_ON[0]` falls at edge 7 and `GATED_CLK[0]` stops; the other channels are unaffected by `BUSY[0]`.
- Wake handshake:
  - Stimulus: channel 2 in OFF, `WAKE_CYC` = 2; assert `WAKE_REQ[2]` before edge k.
  - Required: `GATED_CLK[2]` rises at k+1 and k+2; `WAKE_ACK[2]` is high after edge k+2; it drops when REQ drops.
- Simultaneous events:
  - Stimulus: in DRAIN with counter = `IDLE_THRESH`, `BUSY` = 1 in the same cycle.
  - Required: next state ON, no clock pulse lost.
  - Stimulus: `IDLE_THRESH` lowered from 10 to 2 when counter = 5.
  - Required: OFF at the next edge.
- Glitch check:
  - Stimulus: toggle `CH_ON` via stimulus and `FORCE_ON` asynchronously mid-high-phase of `CLK`.
  - Required: every `GATED_CLK` high pulse is exactly one full `CLK` high phase; no runt pulses (assertion-checked).
- Reset mid-wake:
  - Stimulus: `RST` at edge k+1 of a wake.
  - Required: state ON, with `WAKE_ACK` high in the first cycle after `RST` falls while REQ is held.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: multi-channel automatic clock-gating controller.
// Each channel has an idle-detect / wake state machine that drives a
// glitch-free latch-and-AND clock gate. Channels are fully independent.
//
// Wake handshake (WAKE_REQ / WAKE_ACK), per channel:
//   WAKE_REQ is a level. The requester raises it and holds it until it sees
//   WAKE_ACK. WAKE_ACK is high in every cycle where WAKE_REQ is high and the
//   channel is in ON, so ACK implies the channel clock is running. ACK drops
//   combinationally with REQ. Dropping REQ before ACK does not abort a wake.
module clk_gate_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_CH-1:0]     BUSY,
  input  logic [NUM_CH-1:0]     WAKE_REQ,
  output logic [NUM_CH-1:0]     WAKE_ACK,
  input  logic                  FORCE_ON,
  input  logic [IDLE_W-1:0]     IDLE_THRESH,
  output logic [NUM_CH-1:0]     CH_ON,
  output logic [NUM_CH-1:0]     GATED_CLK,
  // Per-channel FSM state, two bits per channel (ON=0, DRAIN=1, OFF=2, WAKE=3).
  output logic [2*NUM_CH-1:0]   DBG_STATE
);

  typedef enum logic [1:0] {
    ST_ON    = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OFF   = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  localparam logic [IDLE_W-1:0] WAKE_CNT = IDLE_W'(WAKE_CYC);
  localparam logic [IDLE_W-1:0] CNT_ONE  = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] CNT_MAX  = '1;

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  // Shared counter: idle cycles while draining, wake cycles while waking.
  logic [IDLE_W-1:0] cnt_q   [NUM_CH];
  logic [IDLE_W-1:0] cnt_d   [NUM_CH];

  logic [NUM_CH-1:0] act;
  logic [NUM_CH-1:0] gate_en;
  logic [NUM_CH-1:0] gate_lat;

  // A request counts as activity so a requester keeps or brings the clock up.
  assign act = BUSY | WAKE_REQ;

  // Next-state and counter update for every channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_ON: begin
          cnt_d[i] = '0;
          if (!act[i] && (IDLE_THRESH != '0)) begin
            state_d[i] = ST_DRAIN;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ST_DRAIN: begin
          // Activity wins over expiry; the threshold is the live value.
          if (act[i] || (IDLE_THRESH == '0)) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= IDLE_THRESH) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] != CNT_MAX) begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        ST_OFF: begin
          cnt_d[i] = '0;
          if (act[i]) begin
            state_d[i] = ST_WAKE;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ST_WAKE: begin
          // Runs to completion even if the request is withdrawn.
          if (cnt_q[i] == WAKE_CNT) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_ON;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // State and counter registers with synchronous reset to ON.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (RST) begin
        state_q[i] <= ST_ON;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Registered state decode to channel enable, acknowledge and gate enable.
  always_comb begin
    CH_ON     = '0;
    WAKE_ACK  = '0;
    gate_en   = '0;
    DBG_STATE = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      CH_ON[i]             = (state_q[i] != ST_OFF);
      WAKE_ACK[i]          = WAKE_REQ[i] && (state_q[i] == ST_ON) && !RST;
      // Clocks keep running during reset so downstream resets complete.
      gate_en[i]           = CH_ON[i] || FORCE_ON || RST;
      DBG_STATE[2*i +: 2]  = state_q[i];
    end
  end

  // Gate latch: transparent while CLK is low, so enable changes made during
  // the high phase only take effect from the next full high phase.
  always_latch begin
    if (!CLK) begin
      gate_lat <= gate_en;
    end
  end

  assign GATED_CLK = {NUM_CH{CLK}} & gate_lat;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed steps followed by a randomized phase,
// all compared against a behavioural model of each channel.
`timescale 1ns/1ps
module tb_clk_gate_ctrl;

  localparam int NUM_CH   = 4;
  localparam int IDLE_W   = 8;
  localparam int WAKE_CYC = 2;
  localparam int HALF     = 5;

  // Clock / reset and DUT inputs
  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_CH-1:0]    busy = '0;
  logic [NUM_CH-1:0]    wake_req = 4'b0101;
  logic                 force_on = 1'b0;
  logic [IDLE_W-1:0]    idle_thresh = 8'd3;
  logic [NUM_CH-1:0]    wake_ack;
  logic [NUM_CH-1:0]    ch_on;
  logic [NUM_CH-1:0]    gated_clk;
  logic [2*NUM_CH-1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // Pulse monitor bookkeeping
  int                gcnt [NUM_CH];
  time               rise_t [NUM_CH];
  int                bad_pulses = 0;
  logic [NUM_CH-1:0] g_prev = '0;

  // Behavioural channel model: off flag, consecutive idle cycles seen while
  // powered, remaining wake cycles.
  bit m_off  [NUM_CH];
  int m_idle [NUM_CH];
  int m_wake [NUM_CH];

  int snap_a [NUM_CH];
  int snap;

  always #HALF clk = ~clk;

  clk_gate_ctrl #(
    .NUM_CH   (NUM_CH),
    .IDLE_W   (IDLE_W),
    .WAKE_CYC (WAKE_CYC)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .BUSY        (busy),
    .WAKE_REQ    (wake_req),
    .WAKE_ACK    (wake_ack),
    .FORCE_ON    (force_on),
    .IDLE_THRESH (idle_thresh),
    .CH_ON       (ch_on),
    .GATED_CLK   (gated_clk),
    .DBG_STATE   (dbg_state)
  );

  // Every gated high pulse must start with clk high and last one full half period.
  always @(gated_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (gated_clk[i] && !g_prev[i]) begin
        rise_t[i] = $time;
        gcnt[i]++;
        if (clk !== 1'b1) bad_pulses++;
      end
      if (!gated_clk[i] && g_prev[i]) begin
        if (($time - rise_t[i]) != HALF) bad_pulses++;
      end
    end
    g_prev = gated_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_update();
    for (int i = 0; i < NUM_CH; i++) begin
      logic a;
      a = busy[i] | wake_req[i];
      if (rst) begin
        m_off[i] = 1'b0; m_idle[i] = 0; m_wake[i] = 0;
      end else if (m_off[i]) begin
        if (a) begin
          m_off[i] = 1'b0; m_wake[i] = WAKE_CYC;
        end
      end else if (m_wake[i] > 0) begin
        m_wake[i]--;
      end else if (a || idle_thresh == 0) begin
        m_idle[i] = 0;
      end else if (m_idle[i] >= int'(idle_thresh)) begin
        m_off[i] = 1'b1; m_idle[i] = 0;
      end else begin
        m_idle[i]++;
      end
    end
  endfunction

  function automatic logic [NUM_CH-1:0] model_ch_on();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = !m_off[i];
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] model_ack();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++)
      v[i] = wake_req[i] && !m_off[i] && (m_wake[i] == 0) && (m_idle[i] == 0) && !rst;
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] model_en();
    return model_ch_on() | {NUM_CH{force_on | rst}};
  endfunction

  // One clock cycle: expected gate level comes from the enable held during the
  // low phase before the edge; outputs are sampled 1ns after the edge.
  task automatic step();
    logic [NUM_CH-1:0] exp_g;
    exp_g = model_en();
    @(posedge clk);
    model_update();
    #1;
    chk("gated_clk", 32'(gated_clk), 32'(exp_g));
    chk("ch_on", 32'(ch_on), 32'(model_ch_on()));
    chk("wake_ack", 32'(wake_ack), 32'(model_ack()));
    chk("glitch", 32'(bad_pulses), 32'd0);
  endtask

  initial begin
    // Reset: clocks run, all channels on, no acknowledge despite requests.
    snap_a = gcnt;
    repeat (5) step();
    for (int i = 0; i < NUM_CH; i++) chk("rst_pulses", 32'(gcnt[i] - snap_a[i]), 32'd5);
    chk("rst_ch_on", 32'(ch_on), 32'hF);
    chk("rst_ack", 32'(wake_ack), 32'h0);

    // Release: all channels gate off at edge IDLE_THRESH+1 = 4.
    rst = 1'b0;
    wake_req = '0;
    repeat (3) step();
    chk("rel_e3_ch_on", 32'(ch_on), 32'hF);
    step();
    chk("rel_e4_ch_on", 32'(ch_on), 32'h0);

    // Bring everything up with BUSY.
    busy = 4'hF;
    repeat (3) step();
    chk("busy_wake_ch_on", 32'(ch_on), 32'hF);

    // Idle hysteresis on channel 0: pulses at cycles 0 and 3.
    busy = 4'b0001; step();
    busy = 4'b0000; step(); step();
    busy = 4'b0001; step();
    chk("hyst_ch_on", 32'(ch_on), 32'h1);
    busy = 4'b0000;
    for (int n = 1; n <= 3; n++) begin
      step();
      chk("hyst_hold", 32'(ch_on[0]), 32'd1);
    end
    step();
    chk("hyst_off_e7", 32'(ch_on[0]), 32'd0);
    step();
    chk("hyst_gclk_stop", 32'(gated_clk[0]), 32'd0);

    // Wake handshake on channel 2 (currently off).
    wake_req = 4'b0100;
    step();
    snap = gcnt[2];
    chk("wake_k_ch_on", 32'(ch_on[2]), 32'd1);
    chk("wake_k_ack", 32'(wake_ack[2]), 32'd0);
    step();
    chk("wake_k1_gclk", 32'(gated_clk[2]), 32'd1);
    chk("wake_k1_ack", 32'(wake_ack[2]), 32'd0);
    step();
    chk("wake_k2_gclk", 32'(gated_clk[2]), 32'd1);
    chk("wake_k2_ack", 32'(wake_ack[2]), 32'd1);
    chk("wake_pulses", 32'(gcnt[2] - snap), 32'd2);
    wake_req = '0;
    #1;
    chk("wake_drop_ack", 32'(wake_ack[2]), 32'd0);

    // Activity on the same edge as drain expiry keeps channel 1 on.
    busy = 4'b0010;
    repeat (3) step();
    busy = '0;
    repeat (3) step();
    busy = 4'b0010;
    step();
    chk("collide_ch_on", 32'(ch_on[1]), 32'd1);
    busy = '0;
    step();
    chk("collide_gclk", 32'(gated_clk[1]), 32'd1);
    chk("collide_drain", 32'(ch_on[1]), 32'd1);

    // Threshold lowered from 10 to 2 with the drain count at 5.
    idle_thresh = 8'd10;
    repeat (4) step();
    chk("lower_before", 32'(ch_on[1]), 32'd1);
    idle_thresh = 8'd2;
    step();
    chk("lower_off", 32'(ch_on[1]), 32'd0);

    // FORCE_ON and BUSY changed mid high phase.
    #2 force_on = 1'b1;
    step(); step();
    chk("force_gclk", 32'(gated_clk), 32'hF);
    #2 force_on = 1'b0; busy = 4'b1000;
    step();
    #3 busy = 4'b0000;
    repeat (6) step();

    // Reset during a wake of channel 3.
    idle_thresh = 8'd1;
    repeat (4) step();
    chk("rw_off", 32'(ch_on[3]), 32'd0);
    wake_req = 4'b1000;
    step();
    rst = 1'b1;
    step();
    chk("rw_rst_ch_on", 32'(ch_on[3]), 32'd1);
    chk("rw_rst_ack", 32'(wake_ack[3]), 32'd0);
    rst = 1'b0;
    #1;
    chk("rw_ack_after_rst", 32'(wake_ack[3]), 32'd1);
    wake_req = '0;
    step();

    // Randomized traffic with requesters that hold REQ until ACK.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        busy[i] = ($urandom_range(0, 3) == 0);
        if (wake_req[i] && wake_ack[i]) wake_req[i] = 1'b0;
        else if (!wake_req[i] && $urandom_range(0, 7) == 0) wake_req[i] = 1'b1;
      end
      if (c % 20 == 0) idle_thresh = 8'($urandom_range(0, 5));
      force_on = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 0) #2;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
